// File: rtl/urp_pcie_pkg.sv
// Shared widths for the PCIe link loopback: default TLP bus, DLLP word and delivered-TLP counter.
package urp_pcie_pkg;
    localparam int TLP_W_DEF = 268;
    localparam int DLLP_W    = 32;
    localparam int CNT_W     = 16;
endpackage

// File: rtl/urp_pcie_reg_slice.sv
// One-entry valid/ready register slice.
// Latency 1 cycle, full throughput; accepts whenever the slot is empty or draining this cycle.
module urp_pcie_reg_slice #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy
);
    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld && in_rdy) begin
            out_dat <= in_dat;
        end
    end
endmodule

// File: rtl/urp_pcie_link.sv
// TLP forward FIFO with per-entry age gating plus a DLLP register slice; URP_PCIE_LINK_ERRINJ_EN adds single-bit error injection.
// Latency: TLP exactly LATENCY cycles minimum from accept to valid; DLLP 1 cycle.
// Backpressure: tx ready drops only on registered full level; rx data held while valid and not ready.
module urp_pcie_link
    import urp_pcie_pkg::*;
#(
    parameter int TLP_W   = TLP_W_DEF,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TLP_W-1:0]         tx_tlp_data_i,
    input  logic                     tx_tlp_valid_i,
    output logic                     tx_tlp_ready_o,
    output logic [TLP_W-1:0]         rx_tlp_data_o,
    output logic                     rx_tlp_valid_o,
    input  logic                     rx_tlp_ready_i,
    input  logic [DLLP_W-1:0]        dllp_i,
    input  logic                     dllp_valid_i,
    output logic                     dllp_ready_o,
    output logic [DLLP_W-1:0]        dllp_o,
    output logic                     dllp_valid_o,
    input  logic                     dllp_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         tlp_cnt_o
`ifdef URP_PCIE_LINK_ERRINJ_EN
    ,
    input  logic                     err_inj_i,
    input  logic [$clog2(TLP_W)-1:0] err_bit_i
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = 4;
    localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
    localparam logic [AW-1:0] AGE_MAX = AW'(LATENCY);

    logic [TLP_W-1:0] mem [DEPTH];
    logic [AW-1:0]    age [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      level;
    logic             push;
    logic             pop;
    logic [TLP_W-1:0] wr_dat;

    assign tx_tlp_ready_o = (level != FULL);
    assign rx_tlp_valid_o = (level != '0) && (age[rd_ptr] == AGE_MAX);
    assign rx_tlp_data_o  = mem[rd_ptr];
    assign level_o        = level;
    assign push           = tx_tlp_valid_i && tx_tlp_ready_o;
    assign pop            = rx_tlp_valid_o && rx_tlp_ready_i;

`ifdef URP_PCIE_LINK_ERRINJ_EN
    logic                     err_arm;
    logic [$clog2(TLP_W)-1:0] err_pos;
    logic                     use_arm;
    logic [$clog2(TLP_W)-1:0] use_pos;

    // An arm pulse coinciding with an accept corrupts that same TLP.
    assign use_arm = err_arm || err_inj_i;
    assign use_pos = err_inj_i ? err_bit_i : err_pos;
    assign wr_dat  = use_arm ? (tx_tlp_data_i ^ (TLP_W'(1) << use_pos)) : tx_tlp_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_arm <= 1'b0;
        end else if (push) begin
            err_arm <= 1'b0;
        end else if (err_inj_i) begin
            err_arm <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (err_inj_i) begin
            err_pos <= err_bit_i;
        end
    end
`else
    assign wr_dat = tx_tlp_data_i;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            tlp_cnt_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                tlp_cnt_o <= tlp_cnt_o + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Idle slots also age; a fresh write restarts its slot at zero.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PW'(i))) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    urp_pcie_reg_slice #(
        .W(DLLP_W)
    ) u_dllp_slice (
        .clk     (clk),
        .rst     (rst),
        .in_dat  (dllp_i),
        .in_vld  (dllp_valid_i),
        .in_rdy  (dllp_ready_o),
        .out_dat (dllp_o),
        .out_vld (dllp_valid_o),
        .out_rdy (dllp_ready_i)
    );
endmodule

// File: tb/tb_urp_pcie_link.sv
// Directed scoreboard bench for urp_pcie_link with default parameters (TLP_W=268, DEPTH=4, LATENCY=3).
module tb_urp_pcie_link;
    import urp_pcie_pkg::*;
    localparam int TW = TLP_W_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [TW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [31:0]   dllp_in = '0;
    logic          dllp_in_valid = 1'b0;
    logic          dllp_in_ready;
    logic [31:0]   dllp_out;
    logic          dllp_out_valid;
    logic          dllp_out_ready = 1'b0;
    logic [2:0]    level;
    logic [15:0]   cnt;
`ifdef URP_PCIE_LINK_ERRINJ_EN
    logic          err_inj = 1'b0;
    logic [8:0]    err_bit = '0;
`endif

    int            n_cmp = 0;
    int            n_err = 0;
    logic [TW-1:0] exp_q[$];
    logic [31:0]   dllp_q[$];
    logic          prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;
    bit            drv_done;

    always #5 clk = ~clk;

    urp_pcie_link dut (
        .clk            (clk),
        .rst            (rst),
        .tx_tlp_data_i  (tx_data),
        .tx_tlp_valid_i (tx_valid),
        .tx_tlp_ready_o (tx_ready),
        .rx_tlp_data_o  (rx_data),
        .rx_tlp_valid_o (rx_valid),
        .rx_tlp_ready_i (rx_ready),
        .dllp_i         (dllp_in),
        .dllp_valid_i   (dllp_in_valid),
        .dllp_ready_o   (dllp_in_ready),
        .dllp_o         (dllp_out),
        .dllp_valid_o   (dllp_out_valid),
        .dllp_ready_i   (dllp_out_ready),
        .level_o        (level),
`ifdef URP_PCIE_LINK_ERRINJ_EN
        .err_inj_i      (err_inj),
        .err_bit_i      (err_bit),
`endif
        .tlp_cnt_o      (cnt)
    );

    function automatic logic [TW-1:0] mk(input int k);
        return {k[11:0], {8{32'hA5A5A5A5}}};
    endfunction

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && rx_valid) chk("rx_stable", rx_data, prev_data);
            prev_stall = rx_valid && !rx_ready;
            prev_data  = rx_data;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got %h, nothing expected", rx_data);
                end else begin
                    chk("rx_order", rx_data, exp_q.pop_front());
                end
            end
            if (dllp_out_valid && dllp_out_ready) begin
                if (dllp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dllp_unexpected: got %h, nothing expected", dllp_out);
                end else begin
                    chk("dllp_data", TW'(dllp_out), TW'(dllp_q.pop_front()));
                end
            end
        end
    end

    task automatic send(input logic [TW-1:0] d, input logic [TW-1:0] e);
        int c;
        tx_data  = d;
        tx_valid = 1'b1;
        for (c = 0; c < 64; c++) begin
            @(negedge clk);
            if (tx_ready) break;
            @(posedge clk); #1;
        end
        if (c == 64) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_accept_timeout: ready stayed %b, required 1", tx_ready);
        end else begin
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_left", TW'(exp_q.size()), '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        dllp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] bad;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_level", TW'(level), '0);
        chk("rst_cnt", TW'(cnt), '0);
        chk("rst_rx_valid", TW'(rx_valid), '0);
        chk("rst_dllp_valid", TW'(dllp_out_valid), '0);
        chk("rst_tx_ready", TW'(tx_ready), TW'(1));
        chk("rst_dllp_ready", TW'(dllp_in_ready), TW'(1));

        // Single TLP: accepted at E0, valid visible only after E3.
        @(posedge clk); #1;
        rx_ready = 1'b1;
        tx_data  = mk(100);
        tx_valid = 1'b1;
        exp_q.push_back(mk(100));
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s1_latency", TW'(rx_valid), TW'(k == 3));
            if (k < 3) @(posedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("s1_cnt", TW'(cnt), TW'(1));
        chk("s1_level", TW'(level), '0);

        // Fill to DEPTH with the sink stalled; fifth TLP must be refused.
        @(posedge clk); #1;
        rx_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(mk(k), mk(k));
        @(negedge clk);
        chk("s2_ready_full", TW'(tx_ready), '0);
        chk("s2_level_full", TW'(level), TW'(4));
        @(posedge clk); #1;
        tx_data  = mk(5);
        tx_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("s2_hold_ready", TW'(tx_ready), '0);
            chk("s2_hold_level", TW'(level), TW'(4));
            chk("s2_head", rx_data, mk(1));
            @(posedge clk); #1;
        end

        // Release the sink with the fifth TLP still offered.
        rx_ready = 1'b1;
        send(mk(5), mk(5));
        wait_drain();
        @(negedge clk);
        chk("s3_cnt", TW'(cnt), TW'(6));
        chk("s3_level", TW'(level), '0);

        // Sink ready toggling every cycle over ten TLPs.
        do_reset();
        @(negedge clk);
        chk("s4_cnt_clear", TW'(cnt), '0);
        @(posedge clk); #1;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(mk(10 + i), mk(10 + i));
                drv_done = 1'b1;
            end
            begin
                for (int c = 0; c < 400 && !(drv_done && exp_q.size() == 0); c++) begin
                    @(posedge clk); #1;
                    rx_ready = ~rx_ready;
                end
            end
        join
        rx_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("s4_cnt", TW'(cnt), TW'(10));
        chk("s4_level", TW'(level), '0);

        // DLLP slice: pass-through, then stall with a second word.
        @(posedge clk); #1;
        dllp_out_ready = 1'b1;
        dllp_in        = 32'h12345678;
        dllp_in_valid  = 1'b1;
        dllp_q.push_back(32'h12345678);
        @(posedge clk); #1;
        dllp_in_valid = 1'b0;
        @(negedge clk);
        chk("s5_dllp_valid", TW'(dllp_out_valid), TW'(1));
        @(posedge clk); #1;
        dllp_out_ready = 1'b0;
        dllp_in        = 32'hCAFEF00D;
        dllp_in_valid  = 1'b1;
        @(negedge clk);
        chk("s5_empty_ready", TW'(dllp_in_ready), TW'(1));
        chk("s5_empty_valid", TW'(dllp_out_valid), '0);
        @(posedge clk); #1;
        dllp_in = 32'h0BADBEEF;
        @(negedge clk);
        chk("s5_stall_ready", TW'(dllp_in_ready), '0);
        chk("s5_stall_valid", TW'(dllp_out_valid), TW'(1));
        chk("s5_stall_data", TW'(dllp_out), TW'(32'hCAFEF00D));
        @(posedge clk); #1;
        chk("s5_held_data", TW'(dllp_out), TW'(32'hCAFEF00D));
        dllp_q.push_back(32'hCAFEF00D);
        dllp_q.push_back(32'h0BADBEEF);
        dllp_out_ready = 1'b1;
        @(posedge clk); #1;
        dllp_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("s5_dllp_drain", TW'(dllp_q.size()), '0);

        // Reset with three TLPs and a DLLP in flight, plus a TLP offered on the reset edge.
        rx_ready       = 1'b0;
        dllp_out_ready = 1'b0;
        for (int k = 30; k < 33; k++) send(mk(k), mk(k));
        dllp_in       = 32'hDEAD0001;
        dllp_in_valid = 1'b1;
        @(posedge clk); #1;
        dllp_in_valid = 1'b0;
        @(negedge clk);
        chk("s6_level_pre", TW'(level), TW'(3));
        chk("s6_dllp_pre", TW'(dllp_out_valid), TW'(1));
        tx_data  = mk(33);
        tx_valid = 1'b1;
        do_reset();
        tx_valid = 1'b0;
        @(negedge clk);
        chk("s6_level", TW'(level), '0);
        chk("s6_rx_valid", TW'(rx_valid), '0);
        chk("s6_dllp_valid", TW'(dllp_out_valid), '0);
        chk("s6_tx_ready", TW'(tx_ready), TW'(1));
        chk("s6_dllp_ready", TW'(dllp_in_ready), TW'(1));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("s6_no_ghost", TW'(rx_valid), '0);
        chk("s6_cnt", TW'(cnt), '0);

`ifdef URP_PCIE_LINK_ERRINJ_EN
        @(posedge clk); #1;
        rx_ready = 1'b1;
        err_bit  = '0;
        err_inj  = 1'b1;
        @(posedge clk); #1;
        err_inj = 1'b0;
        bad = mk(40);
        bad[0] = ~bad[0];
        send(mk(40), bad);
        send(mk(41), mk(41));
        wait_drain();
`endif

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
